// File: rtl/pdm_dac_tx.sv
// ============================================================================
//  Module      : pdm_dac_tx
//  Description : Sample FIFO feeding a first-order sigma-delta PDM modulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_dac_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OSR        = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         sample_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    input  logic                          mute_i,
    input  logic                          clear_underrun_i,
    output logic                          pdm_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_PW = $clog2(OSR);
    localparam logic [DATA_WIDTH-1:0] c_MID        = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [c_PW-1:0]       c_LAST_PHASE = c_PW'(OSR - 1);
    localparam logic [c_LW-1:0]       c_FULL       = c_LW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    logic [c_PW-1:0]       r_phase;
    logic [DATA_WIDTH-1:0] r_cur;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_pdm;
    logic                  r_underrun;

    logic                  w_push;
    logic                  w_wrap;
    logic                  w_empty;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_m;
    logic [DATA_WIDTH:0]   w_sum;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never frees a slot for a push.
    assign sample_ready_o = (r_level != c_FULL);
    assign w_push         = sample_valid_i && sample_ready_o;
    assign w_wrap         = (r_phase == c_LAST_PHASE);
    assign w_empty        = (r_level == '0);
    assign w_pop          = w_wrap && !w_empty;
    assign w_m            = mute_i ? c_MID : r_cur;
    assign w_sum          = {1'b0, r_acc} + {1'b0, w_m};

    assign pdm_o      = r_pdm;
    assign underrun_o = r_underrun;
    assign level_o    = r_level;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase    <= '0;
            r_cur      <= c_MID;
            r_underrun <= 1'b0;
        end else begin
            r_phase <= w_wrap ? '0 : r_phase + c_PW'(1);
            if (w_pop) begin
                r_cur <= r_mem[r_rd_ptr];
            end
            // A fresh underrun outranks a simultaneous clear request.
            if (w_wrap && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun_i) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // The accumulator carry is the PDM bit; its ones-density tracks m/2^N.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else begin
            r_acc <= w_sum[DATA_WIDTH-1:0];
            r_pdm <= w_sum[DATA_WIDTH];
        end
    end

endmodule

`default_nettype wire
